instr_word_encoder: RTL and testbench
=====================================

// Module: instr_word_encoder
// PURPOSE
//  Inverse of the core decode path: packs op/func3/func11/register/immediate fields into 32-bit ISA words
//  and streams them with target addresses to the instruction-memory loader (boot/test program injection).
//  Expands pseudo-instruction LI (32-bit constant) into CLIR, CUIR or CUIR+ADDI. Sits between host/debug port and imem.
// PARAMETERS
//  ADDR_WIDTH  16  width of word_addr; address wraps modulo 2^ADDR_WIDTH
//  BASE_ADDR   0   address of first word after reset
//  ADDR_STEP   4   increment applied after each accepted word
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  addr_load   in   1   load addr_value as next word address (honoured only in IDLE)
//  addr_value  in   AW  address to load
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   high only in IDLE
//  cmd_li      in   1   1: LI pseudo (uses cmd_rd, cmd_imm); 0: raw encode
//  cmd_op      in   3   op type A..H
//  cmd_func3   in   3   subtype
//  cmd_func11  in   11  type-A prefix
//  cmd_rd/rs1/rs2 in 5  register indices
//  cmd_imm     in   32  immediate, two's complement
//  word_valid  out  1   encoded word present
//  word_ready  in   1   consumer accepts
//  word_data   out  32  encoded instruction
//  word_addr   out  AW  address of word_data
//  err         out  1   1-cycle pulse: command rejected (range-check build only)
// BEHAVIOUR
//  Field layout: op[2:0], rd[7:3], func3[10:8], rs1[15:11], rs2[20:16], func11[31:21].
//  A/E/H: full layout. B,F: imm16 in [31:16]. D: imm21 in [31:11].
//  C: imm[4:0]->[7:3], imm[15:5]->[31:21]. G: imm[6:2]->[7:3], imm[18:7]->[31:21], imm[1:0] dropped.
//  Unused fields/immediate bits truncated to field width.
//  FSM: IDLE -> EMIT1 on cmd_valid; EMIT1 -> EMIT2 on word_ready if LI needs 2 words, else IDLE; EMIT2 -> IDLE on word_ready.
//  Latency: cmd accepted at edge N -> word_valid, registered word_data, word_addr valid after edge N.
//  word_data/word_addr stable while word_valid && !word_ready; word_valid never drops without handshake.
//  Each handshake: addr += ADDR_STEP (wrap, no flag). cmd_ready=0 in EMIT1/EMIT2.
//  LI: imm fits signed 21 -> CLIR(op 011,f3 000,imm21=imm[20:0]); else CUIR(op 011,f3 001,imm21=imm[31:11]),
//   then if imm[10:0]!=0 ADDI(op 001,f3 000,rd,rs1=rd,imm16={5'b0,imm[10:0]}).
//  addr_load with cmd accept in same cycle: first word uses addr_value. addr_load outside IDLE ignored.
//  Reset (any state, async): IDLE, word_valid=0, word_data=0, word_addr=BASE_ADDR, err=0, cmd_ready=1 after release.
// CONFIGURATION
//  ENCODER_RANGE_CHECK_EN defined: command accepted, no word emitted, err pulses 1 cycle, stays IDLE, addr unchanged, if:
//   op E/H; B with func3[2]=1 and imm[31:16]!=0; B(func3[2]=0)/C/F imm not signed-16; D CLIR/JLL not signed-21;
//   D CUIR imm[31:21]!=0; G imm[1:0]!=0 or not signed-19. LI never errors.
//  Not defined: no checks, silent truncation, err tied 0; E/H encoded with type-A layout.
// TESTING
//  Raw A: op0 rd1 f3 0 rs1 2 rs2 3 f11 0 at addr 0 -> word 0x00031008 addr 0x0000, next word addr 0x0004.
//  LI rd5 imm 0x12345678 -> 0x1234512B then 0x06782829 at consecutive addrs; cmd_ready low for both.
//  LI rd2 imm 0xFFFFFFFF -> single 0xFFFFF813; LI rd1 imm 0x00200000 -> single 0x0020010B.
//  Backpressure: word_ready low 3 cycles -> data/addr unchanged, cmd_ready 0; ready high -> one handshake only.
//  ADDR_WIDTH=4, addr_load 12 + LI needing 2 words -> addrs 12 then 0. Reset asserted in EMIT2 -> word_valid 0 at once.
//  RANGE_CHECK build: G imm 6 -> err 1 cycle, no word_valid, addr unchanged; non-check build -> word emitted.

Source files
------------

// File: rtl/instr_word_encoder_if.sv
// Command/word bus between a host port and instr_word_encoder.
// Handshake: a transfer occurs on a rising clk edge where valid && ready are both high; a producer
// holding valid keeps its payload stable and may not drop valid until that edge; ready may be asserted
// independently of valid.
interface instr_word_encoder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  addr_load;
  logic [ADDR_WIDTH-1:0] addr_value;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_li;
  logic [2:0]            cmd_op;
  logic [2:0]            cmd_func3;
  logic [10:0]           cmd_func11;
  logic [4:0]            cmd_rd;
  logic [4:0]            cmd_rs1;
  logic [4:0]            cmd_rs2;
  logic [31:0]           cmd_imm;
  logic                  word_valid;
  logic                  word_ready;
  logic [31:0]           word_data;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  err;

  modport master (
    output addr_load, addr_value, cmd_valid, cmd_li, cmd_op, cmd_func3, cmd_func11,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, word_ready,
    input  cmd_ready, word_valid, word_data, word_addr, err
  );

  modport slave (
    input  addr_load, addr_value, cmd_valid, cmd_li, cmd_op, cmd_func3, cmd_func11,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, word_ready,
    output cmd_ready, word_valid, word_data, word_addr, err
  );
endinterface

// File: rtl/instr_word_encoder.sv
// Packs instruction fields (or an LI pseudo-op) into 32-bit words streamed with addresses to imem.
// Optional feature: define ENCODER_RANGE_CHECK_EN to reject commands whose immediates do not fit.
module instr_word_encoder #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_word_encoder_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT1 = 2'd1,
    S_EMIT2 = 2'd2
  } state_e;

  localparam logic [2:0] OP_A = 3'd0, OP_B = 3'd1, OP_C = 3'd2, OP_D = 3'd3;
  localparam logic [2:0] OP_E = 3'd4, OP_F = 3'd5, OP_G = 3'd6, OP_H = 3'd7;

  state_e                state_q;
  logic                  word_valid_q;
  logic [31:0]           word_data_q;
  logic [31:0]           word2_q;
  logic                  need2_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q;

  logic [31:0] imm;
  logic [4:0]  rd;
  logic [2:0]  op;
  logic [2:0]  f3;
  logic [31:0] raw_word;
  logic [31:0] clir_word;
  logic [31:0] cuir_word;
  logic [31:0] addi_word;
  logic [31:0] first_word;
  logic        fits21;
  logic        li_two;
  logic        reject;

  assign imm = bus.cmd_imm;
  assign rd  = bus.cmd_rd;
  assign op  = bus.cmd_op;
  assign f3  = bus.cmd_func3;

  always_comb begin
    raw_word = '0;
    case (op)
      OP_B, OP_F: raw_word = {imm[15:0], bus.cmd_rs1, f3, rd, op};
      OP_C:       raw_word = {imm[15:5], bus.cmd_rs2, bus.cmd_rs1, f3, imm[4:0], op};
      OP_D:       raw_word = {imm[20:0], f3, rd, op};
      // 12 immediate bits would not fit the 11-bit top field; the MSB is truncated away.
      OP_G:       raw_word = {imm[17:7], bus.cmd_rs2, bus.cmd_rs1, f3, imm[6:2], op};
      default:    raw_word = {bus.cmd_func11, bus.cmd_rs2, bus.cmd_rs1, f3, rd, op};
    endcase
  end

  assign fits21     = (imm[31:20] == {12{imm[20]}});
  assign clir_word  = {imm[20:0], 3'b000, rd, OP_D};
  assign cuir_word  = {imm[31:11], 3'b001, rd, OP_D};
  assign addi_word  = {5'b00000, imm[10:0], rd, 3'b000, rd, OP_B};
  assign li_two     = !fits21 && (imm[10:0] != 11'd0);
  assign first_word = bus.cmd_li ? (fits21 ? clir_word : cuir_word) : raw_word;

`ifdef ENCODER_RANGE_CHECK_EN
  logic fits16;
  logic fits19;
  assign fits16 = (imm[31:15] == {17{imm[15]}});
  assign fits19 = (imm[31:18] == {14{imm[18]}});

  always_comb begin
    reject = 1'b0;
    if (!bus.cmd_li) begin
      case (op)
        OP_E, OP_H: reject = 1'b1;
        OP_B:       reject = f3[2] ? (imm[31:16] != 16'd0) : !fits16;
        OP_C, OP_F: reject = !fits16;
        OP_D:       reject = (f3 == 3'b001) ? (imm[31:21] != 11'd0) : !fits21;
        OP_G:       reject = (imm[1:0] != 2'b00) || !fits19;
        default:    reject = 1'b0;
      endcase
    end
  end
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word2_q      <= '0;
      need2_q      <= 1'b0;
      addr_q       <= ADDR_WIDTH'(BASE_ADDR);
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.addr_load) addr_q <= bus.addr_value;
          if (bus.cmd_valid) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              word_data_q  <= first_word;
              word2_q      <= addi_word;
              need2_q      <= bus.cmd_li && li_two;
              word_valid_q <= 1'b1;
              state_q      <= S_EMIT1;
            end
          end
        end
        S_EMIT1: begin
          if (bus.word_ready) begin
            addr_q <= addr_q + ADDR_WIDTH'(ADDR_STEP);
            if (need2_q) begin
              word_data_q <= word2_q;
              state_q     <= S_EMIT2;
            end else begin
              word_valid_q <= 1'b0;
              state_q      <= S_IDLE;
            end
          end
        end
        S_EMIT2: begin
          if (bus.word_ready) begin
            addr_q       <= addr_q + ADDR_WIDTH'(ADDR_STEP);
            word_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          word_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_addr  = addr_q;
  assign bus.err        = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: stimulus pushes expected {addr,data} words into a queue,
// a negedge monitor pops and compares on every word handshake.
module tb_instr_word_encoder;
  localparam int AW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  instr_word_encoder_if #(.ADDR_WIDTH(AW)) bus();

  instr_word_encoder #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (0),
    .ADDR_STEP (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int              n_vec    = 0;
  int              n_miss   = 0;
  int              err_seen = 0;
  logic [AW+31:0]  exp_q[$];
  logic [AW+31:0]  mon_e;
  logic [AW-1:0]   exp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d);
    exp_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 16'd4;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_word: got 0x%08h at 0x%04h, expected none", bus.word_data, bus.word_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word_data", bus.word_data, mon_e[31:0]);
        chk("word_addr", 32'(bus.word_addr), 32'(mon_e[AW+31:32]));
      end
    end
    if (!rst && bus.err) err_seen++;
  end

  task automatic issue(input logic li, input logic [2:0] op, input logic [2:0] f3,
                       input logic [10:0] f11, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic ld, input logic [AW-1:0] lval);
    @(posedge clk); #1;
    bus.cmd_li     = li;
    bus.cmd_op     = op;
    bus.cmd_func3  = f3;
    bus.cmd_func11 = f11;
    bus.cmd_rd     = rd;
    bus.cmd_rs1    = rs1;
    bus.cmd_rs2    = rs2;
    bus.cmd_imm    = imm;
    bus.addr_load  = ld;
    bus.addr_value = lval;
    bus.cmd_valid  = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
    bus.addr_load  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: cmd_ready still %b after 50 cycles, expected 1", name, bus.cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a0;
    int            err_before;

    bus.addr_load  = 1'b0;
    bus.addr_value = '0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_li     = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_func3  = '0;
    bus.cmd_func11 = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_imm    = '0;
    bus.word_ready = 1'b1;
    exp_addr       = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_word_data",  bus.word_data, 32'd0);
    chk("rst_word_addr",  32'(bus.word_addr), 32'd0);
    chk("rst_err",        32'(bus.err), 32'd0);
    chk("rst_cmd_ready",  32'(bus.cmd_ready), 32'd1);

    // raw type A with explicit address load
    exp_addr = 16'h0000;
    expect_word(32'h00031008);
    issue(1'b0, 3'd0, 3'd0, 11'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 16'h0000);
    wait_idle("raw_a");
    chk("raw_a_next_addr", 32'(bus.word_addr), 32'h0004);

    // LI needing CUIR + ADDI
    expect_word(32'h1234512B);
    expect_word(32'h06782829);
    issue(1'b1, 3'd0, 3'd0, 11'd0, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b0, '0);
    wait_idle("li_two");

    // LI fitting signed 21 -> CLIR; LI with zero low bits -> CUIR only
    expect_word(32'hFFFFF813);
    issue(1'b1, 3'd0, 3'd0, 11'd0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, '0);
    wait_idle("li_clir");
    expect_word(32'h0020010B);
    issue(1'b1, 3'd0, 3'd0, 11'd0, 5'd1, 5'd0, 5'd0, 32'h00200000, 1'b0, '0);
    wait_idle("li_cuir");
    chk("li_next_addr", 32'(bus.word_addr), 32'(exp_addr));

    // raw B, D, C layouts
    expect_word(32'h12342219);
    issue(1'b0, 3'd1, 3'd2, 11'd0, 5'd3, 5'd4, 5'd0, 32'h00001234, 1'b0, '0);
    wait_idle("raw_b");
    expect_word(32'h55E6F23B);
    issue(1'b0, 3'd3, 3'd2, 11'd0, 5'd7, 5'd0, 5'd0, 32'h000ABCDE, 1'b0, '0);
    wait_idle("raw_d");
    expect_word(32'h7FEA4DFA);
    issue(1'b0, 3'd2, 3'd5, 11'd0, 5'd3, 5'd9, 5'd10, 32'h00007FFF, 1'b0, '0);
    wait_idle("raw_c");

    // G with imm[1:0] != 0: rejected only in the range-check build
    err_before = err_seen;
`ifdef ENCODER_RANGE_CHECK_EN
    issue(1'b0, 3'd6, 3'd0, 11'd0, 5'd0, 5'd0, 5'd0, 32'd6, 1'b0, '0);
    wait_idle("raw_g");
    repeat (2) @(posedge clk);
    #1;
    chk("g_err_cycles", 32'(err_seen - err_before), 32'd1);
`else
    expect_word(32'h0000000E);
    issue(1'b0, 3'd6, 3'd0, 11'd0, 5'd0, 5'd0, 5'd0, 32'd6, 1'b0, '0);
    wait_idle("raw_g");
    repeat (2) @(posedge clk);
    #1;
    chk("g_err_cycles", 32'(err_seen - err_before), 32'd0);
`endif
    chk("g_next_addr", 32'(bus.word_addr), 32'(exp_addr));

    // address wrap across the top of the address space
    exp_addr = 16'hFFFC;
    expect_word(32'h1234512B);
    expect_word(32'h06782829);
    issue(1'b1, 3'd0, 3'd0, 11'd0, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b1, 16'hFFFC);
    wait_idle("wrap");
    chk("wrap_next_addr", 32'(bus.word_addr), 32'h0004);

    // backpressure, plus addr_load outside IDLE must be ignored
    bus.word_ready = 1'b0;
    a0 = exp_addr;
    expect_word(32'h1234512B);
    expect_word(32'h06782829);
    issue(1'b1, 3'd0, 3'd0, 11'd0, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b0, '0);
    bus.addr_load  = 1'b1;
    bus.addr_value = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_data",      bus.word_data, 32'h1234512B);
      chk("bp_addr",      32'(bus.word_addr), 32'(a0));
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.addr_load  = 1'b0;
    bus.word_ready = 1'b1;
    @(posedge clk); #1;
    bus.word_ready = 1'b0;
    chk("bp_second_data",  bus.word_data, 32'h06782829);
    chk("bp_second_addr",  32'(bus.word_addr), 32'(a0 + 16'd4));
    chk("bp_second_valid", 32'(bus.word_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_data", bus.word_data, 32'h06782829);
    bus.word_ready = 1'b1;
    wait_idle("bp");
    chk("bp_next_addr", 32'(bus.word_addr), 32'(exp_addr));

    // asynchronous reset while the second LI word is pending
    bus.word_ready = 1'b0;
    expect_word(32'h1234512B);
    expect_word(32'h06782829);
    issue(1'b1, 3'd0, 3'd0, 11'd0, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b0, '0);
    bus.word_ready = 1'b1;
    @(posedge clk); #1;
    bus.word_ready = 1'b0;
    chk("emit2_state", 32'(dbg_state), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_word_valid", 32'(bus.word_valid), 32'd0);
    chk("arst_word_addr",  32'(bus.word_addr), 32'd0);
    chk("arst_state",      32'(dbg_state), 32'd0);
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.word_ready = 1'b1;
    exp_addr = '0;
    @(posedge clk); #1;
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // after reset the stream restarts at BASE_ADDR
    expect_word(32'h00031008);
    issue(1'b0, 3'd0, 3'd0, 11'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, '0);
    wait_idle("post_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
